// File: rtl/load_store_unit.sv
// Load/store front end for dual_port_memory_group. Handles one request at a time and always returns a held response.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int DATA_DEPTH   = 4096,
  parameter int READ_LATENCY = 1,
  localparam int ADDR_W      = 2 + $clog2(DATA_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [3:0]        mem_write_mask,
  output logic [ADDR_W-1:0] mem_addr_a,
  output logic [ADDR_W-1:0] mem_addr_b,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] STORE     = 2'd1;
  localparam logic [1:0] LOAD_WAIT = 2'd2;
  localparam logic [1:0] RESP      = 2'd3;

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid may not depend on ready, and a producer holds its payload stable until the transfer.

  logic [1:0]        state_q, state_d;
  logic [3:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              accept;
  logic              trap_hit;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] sz,
                                         input logic uns);
    case (sz)
      2'd0:    extend = {{24{~uns & d[7]}}, d[7:0]};
      2'd1:    extend = {{16{~uns & d[15]}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign accept = req_valid && (state_q == IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  assign trap_hit = ((req_size == 2'd1) && req_addr[0]) ||
                    (req_size[1] && (req_addr[1:0] != 2'b00));

  // Every accepted request re-evaluates the fault flag, so it is held through RESP.
  always_comb begin
    fault_d = fault_q;
    if (accept) fault_d = trap_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end

  assign resp_fault = fault_q;
`else
  assign trap_hit   = 1'b0;
  assign resp_fault = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    uns_d        = uns_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          uns_d   = req_unsigned;
          cnt_d   = '0;
          if (trap_hit) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            rdata_d      = 32'd0;
          end else if (req_we) begin
            state_d = STORE;
            mask_d  = size_mask(req_size);
          end else begin
            state_d = LOAD_WAIT;
          end
        end
      end
      STORE: begin
        // The memory commits the write on this edge; the mask drops with it.
        mask_d       = 4'b0000;
        state_d      = RESP;
        resp_valid_d = 1'b1;
        rdata_d      = 32'd0;
      end
      LOAD_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          rdata_d      = extend(mem_read_data, size_q, uns_q);
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mask_q       <= 4'b0000;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = rdata_q;
  assign mem_write_mask = mask_q;
  assign mem_addr_a     = addr_q;
  assign mem_addr_b     = addr_q;
  assign mem_write_data = wdata_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory model with address-realigned reads, two DUTs
// (READ_LATENCY 1 and 3). Honours LSU_MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
    logic [3:0]  exp_mask;
    int          stall;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT 1 (READ_LATENCY = 1)
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [13:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_fault;
  logic [31:0] resp_rdata, mem_write_data, mem_read_data;
  logic [3:0]  mem_write_mask;
  logic [13:0] mem_addr_a, mem_addr_b;
  logic [1:0]  dbg_state;

  // DUT 2 (READ_LATENCY = 3), loads only
  logic        req_valid2 = 1'b0, req_we2 = 1'b0, req_unsigned2 = 1'b0, resp_ready2 = 1'b0;
  logic [1:0]  req_size2 = 2'd0;
  logic [13:0] req_addr2 = '0;
  logic [31:0] req_wdata2 = '0;
  logic        req_ready2, resp_valid2, resp_fault2;
  logic [31:0] resp_rdata2, mem_write_data2, mem_read_data2;
  logic [3:0]  mem_write_mask2;
  logic [13:0] mem_addr_a2, mem_addr_b2;
  logic [1:0]  dbg_state2;

  load_store_unit #(.DATA_DEPTH(4096), .READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_write_mask(mem_write_mask), .mem_addr_a(mem_addr_a),
    .mem_addr_b(mem_addr_b), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .dbg_state(dbg_state)
  );

  load_store_unit #(.DATA_DEPTH(4096), .READ_LATENCY(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
    .req_size(req_size2), .req_unsigned(req_unsigned2), .req_addr(req_addr2),
    .req_wdata(req_wdata2), .resp_valid(resp_valid2), .resp_ready(resp_ready2),
    .resp_rdata(resp_rdata2), .resp_fault(resp_fault2), .mem_write_mask(mem_write_mask2),
    .mem_addr_a(mem_addr_a2), .mem_addr_b(mem_addr_b2), .mem_write_data(mem_write_data2),
    .mem_read_data(mem_read_data2), .dbg_state(dbg_state2)
  );

  // Memory model: little-endian bytes, writes on the clock edge under the mask, reads realigned
  // to the byte address. A READ_LATENCY of L is modelled as L-1 register stages after the lookup.
  bit   [7:0]  mem [0:16383];
  logic [31:0] rd1, rd2, p1, p2;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_write_mask[i]) mem[mem_addr_a + 14'(i)] <= mem_write_data[8*i +: 8];
  end

  always @* begin
    for (int i = 0; i < 4; i++) begin
      rd1[8*i +: 8] = mem[mem_addr_b + 14'(i)];
      rd2[8*i +: 8] = mem[mem_addr_b2 + 14'(i)];
    end
  end

  always @(posedge clk) begin
    p1 <= rd2;
    p2 <= p1;
  end

  assign mem_read_data  = rd1;
  assign mem_read_data2 = p2;

  // scoreboard
  logic [32:0] exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [13:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic fault, input int stall);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_fault = fault; v.stall = stall;
    v.exp_lat  = fault ? 1 : 2;
    v.exp_mask = (fault || !we) ? 4'b0000 : (size == 2'd0) ? 4'b0001 :
                 (size == 2'd1) ? 4'b0011 : 4'b1111;
    return v;
  endfunction

  // driver for DUT 1
  task automatic run_vec(input vec_t v);
    int cyc;
    logic [32:0] e;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    exp_q.push_back({v.exp_fault, v.exp_rdata});
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata = $urandom;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      chk("mem_write_mask", mem_write_mask, (cyc == 1) ? v.exp_mask : 4'b0000);
      if (cyc == 1) begin
        chk("mem_addr_a", mem_addr_a, v.addr);
        chk("mem_addr_b", mem_addr_b, v.addr);
        if (v.we && !v.exp_fault) chk("mem_write_data", mem_write_data, v.wdata);
      end
      if (resp_valid) break;
    end
    chk("resp_latency", cyc, v.exp_lat);
    if (resp_valid) begin
      e = exp_q.pop_front();
      chk("resp_rdata", resp_rdata, e[31:0]);
      chk("resp_fault", resp_fault, e[32]);
      for (int k = 0; k < v.stall; k++) begin
        req_valid = (k == 2); req_we = 1'b1; req_size = 2'd2; req_addr = v.addr;
        req_wdata = 32'h0;
        @(negedge clk);
        chk("stall_resp_valid", resp_valid, 1);
        chk("stall_resp_rdata", resp_rdata, e[31:0]);
        chk("stall_req_ready", req_ready, 0);
        chk("stall_mask", mem_write_mask, 4'b0000);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
      chk("resp_valid_drop", resp_valid, 0);
      chk("req_ready_return", req_ready, 1);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  // driver for DUT 2 (READ_LATENCY = 3)
  task automatic run_load2(input logic [1:0] size, input logic uns, input logic [13:0] addr,
                           input logic [31:0] exp_rdata);
    int cyc;
    @(negedge clk);
    req_valid2 = 1'b1; req_size2 = size; req_unsigned2 = uns; req_addr2 = addr;
    @(posedge clk);
    #1 req_valid2 = 1'b0;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (resp_valid2) break;
    end
    chk("rl3_latency", cyc, 4);
    chk("rl3_rdata", resp_rdata2, exp_rdata);
    chk("rl3_mask", mem_write_mask2, 4'b0000);
    resp_ready2 = 1'b1;
    @(posedge clk);
    #1 resp_ready2 = 1'b0;
  endtask

  initial begin
    // reset values
    repeat (2) @(negedge clk);
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_mask", mem_write_mask, 4'b0000);
    chk("rst_addr_a", mem_addr_a, 14'd0);
    chk("rst_addr_b", mem_addr_b, 14'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_fault", resp_fault, 0);
    chk("rst_req_ready", req_ready, 1);
    rst_n = 1'b1;

    vecs.push_back(mk(1, 2'd2, 0, 14'h0010, 32'hDEADBEEF, 32'h0, 0, 0));
    vecs.push_back(mk(0, 2'd2, 0, 14'h0010, 32'h0, 32'hDEADBEEF, 0, 0));
    vecs.push_back(mk(1, 2'd0, 0, 14'h0013, 32'h12345680, 32'h0, 0, 0));
    vecs.push_back(mk(0, 2'd0, 0, 14'h0013, 32'h0, 32'hFFFFFF80, 0, 0));
    vecs.push_back(mk(0, 2'd0, 1, 14'h0013, 32'h0, 32'h00000080, 0, 0));
    vecs.push_back(mk(0, 2'd1, 0, 14'h0011, 32'h0, TRAP ? 32'h0 : 32'hFFFFADBE, TRAP, 0));
    vecs.push_back(mk(0, 2'd2, 0, 14'h0010, 32'h0, 32'h80ADBEEF, 0, 5));
    vecs.push_back(mk(0, 2'd2, 0, 14'h0010, 32'h0, 32'h80ADBEEF, 0, 0));
    vecs.push_back(mk(1, 2'd1, 0, 14'h0020, 32'h1234CAFE, 32'h0, 0, 0));
    vecs.push_back(mk(0, 2'd1, 1, 14'h0020, 32'h0, 32'h0000CAFE, 0, 0));
    vecs.push_back(mk(0, 2'd1, 0, 14'h0020, 32'h0, 32'hFFFFCAFE, 0, 0));
    vecs.push_back(mk(0, 2'd2, 1, 14'h0020, 32'h0, 32'h0000CAFE, 0, 0));
    vecs.push_back(mk(1, 2'd3, 0, 14'h0030, 32'h55667788, 32'h0, 0, 0));
    vecs.push_back(mk(0, 2'd3, 0, 14'h0030, 32'h0, 32'h55667788, 0, 0));
    vecs.push_back(mk(1, 2'd2, 0, 14'h3FFE, 32'hA1B2C3D4, 32'h0, TRAP, 0));
    vecs.push_back(mk(0, 2'd0, 1, 14'h0001, 32'h0, TRAP ? 32'h0 : 32'h000000A1, 0, 0));
    vecs.push_back(mk(0, 2'd0, 1, 14'h3FFF, 32'h0, TRAP ? 32'h0 : 32'h000000C3, 0, 0));
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // READ_LATENCY = 3
    run_load2(2'd2, 1'b0, 14'h0010, 32'h80ADBEEF);
    run_load2(2'd0, 1'b0, 14'h0013, 32'hFFFFFF80);

    // asynchronous reset while in STORE aborts the write and drops the response
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 14'h0010; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2;
    chk("abort_mask_before", mem_write_mask, 4'b1111);
    chk("abort_state_before", dbg_state, 2'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_mask", mem_write_mask, 4'b0000);
    chk("abort_state", dbg_state, 2'd0);
    chk("abort_resp_valid", resp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_resp", resp_valid, 0);
    end
    run_vec(mk(0, 2'd2, 0, 14'h0010, 32'h0, 32'h80ADBEEF, 0, 0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
